// File: rtl/lane_par2serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : lane_par2serial_tx
// Description : Tx lane serialiser. After reset it sends SYNC_SYMBOLS COM
//               training symbols, then streams each valid lane byte MSB-first
//               on a 1-bit line. IDLE_SYM fills every symbol slot where the
//               byte is not valid. One 8-bit symbol every 8 clk_16f cycles,
//               with no gaps.
// Ports       : clk_16f      - bit clock, rising edge
//               reset        - synchronous, active-high
//               data_in      - lane byte from the 4-to-2 mux stage
//               valid_in     - data_in qualifier, sampled on load edges only
//               serial_out   - serial bit stream, MSB first
//               symbol_start - high while serial_out carries bit 7
//               byte_taken   - one-cycle pulse, a valid byte was consumed
//               link_active  - high once data/idle symbols are being sent
// Revision    : 1.0 - initial release
// ============================================================================
module lane_par2serial_tx #(
  parameter int unsigned SYNC_SYMBOLS = 4,
  parameter logic [7:0]  COM_SYM      = 8'hBC,
  parameter logic [7:0]  IDLE_SYM     = 8'h7C
) (
  input  logic       clk_16f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       serial_out,
  output logic       symbol_start,
  output logic       byte_taken,
  output logic       link_active
);

  // Sized to hold SYNC_SYMBOLS itself: the final SYNC load edge still
  // increments, so the counter never wraps.
  localparam int unsigned c_CNT_W = $clog2(SYNC_SYMBOLS + 1);
  localparam logic [c_CNT_W-1:0] c_SYNC_LAST = c_CNT_W'(SYNC_SYMBOLS - 1);

  localparam logic [0:0] c_ST_SYNC   = 1'b0;
  localparam logic [0:0] c_ST_ACTIVE = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_next;
  logic [c_CNT_W-1:0] r_sym_count;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;

  logic               w_load;
  logic [7:0]         w_sym;
  logic               w_take;

  // A symbol boundary is wherever the bit counter has wrapped to zero,
  // including the first edge after reset.
  assign w_load = (r_bit_cnt == 3'd0);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_16f) begin
    if (reset) begin
      r_state <= c_ST_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: leave SYNC on the load edge that sends the last COM.
  // ACTIVE is only left through reset.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_SYNC: begin
        if (w_load && (r_sym_count == c_SYNC_LAST)) begin
          w_state_next = c_ST_ACTIVE;
        end
      end
      c_ST_ACTIVE: w_state_next = c_ST_ACTIVE;
      default:     w_state_next = c_ST_SYNC;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: the symbol to load, and whether it consumes a byte
  // --------------------------------------------------------------------------
  always_comb begin
    w_sym  = COM_SYM;
    w_take = 1'b0;
    case (r_state)
      c_ST_SYNC: begin
        w_sym  = COM_SYM;
        w_take = 1'b0;
      end
      c_ST_ACTIVE: begin
        w_sym  = valid_in ? data_in : IDLE_SYM;
        w_take = valid_in;
      end
      default: begin
        w_sym  = COM_SYM;
        w_take = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Serialiser datapath. Bit 7 is emitted directly on the load edge; the
  // shift register holds the remaining 7 bits, left-aligned.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_16f) begin
    if (reset) begin
      serial_out   <= 1'b0;
      symbol_start <= 1'b0;
      byte_taken   <= 1'b0;
      link_active  <= 1'b0;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_sym_count  <= '0;
    end else if (w_load) begin
      serial_out   <= w_sym[7];
      r_shift      <= {w_sym[6:0], 1'b0};
      r_bit_cnt    <= 3'd1;
      symbol_start <= 1'b1;
      byte_taken   <= w_take;
      if (r_state == c_ST_ACTIVE) begin
        link_active <= 1'b1;
      end
      if (r_state == c_ST_SYNC) begin
        r_sym_count <= r_sym_count + 1'b1;
      end
    end else begin
      serial_out   <= r_shift[7];
      r_shift      <= {r_shift[6:0], 1'b0};
      r_bit_cnt    <= r_bit_cnt + 3'd1;   // 7 -> 0 wraps naturally
      symbol_start <= 1'b0;
      byte_taken   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lane_par2serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_par2serial_tx
// Description : Self-checking bench for lane_par2serial_tx. A symbol-level
//               reference model (symbol index and bit position over time)
//               predicts every output each cycle; scenario tasks also
//               reassemble transmitted symbols and compare them to literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_par2serial_tx;

  localparam int unsigned SYNC_SYMBOLS = 4;

  logic       clk_16f;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       serial_out;
  logic       symbol_start;
  logic       byte_taken;
  logic       link_active;

  int n_tests;
  int n_fail;

  // Reference model: time since reset measured in symbols and bit positions.
  int         m_pos;
  int         m_nsym;
  logic [7:0] m_cur;
  logic       m_tk;
  logic       m_link;
  logic       exp_s, exp_st, exp_bt, exp_la;

  lane_par2serial_tx #(
    .SYNC_SYMBOLS (SYNC_SYMBOLS),
    .COM_SYM      (8'hBC),
    .IDLE_SYM     (8'h7C)
  ) dut (
    .clk_16f      (clk_16f),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .serial_out   (serial_out),
    .symbol_start (symbol_start),
    .byte_taken   (byte_taken),
    .link_active  (link_active)
  );

  initial clk_16f = 1'b0;
  always #5 clk_16f = ~clk_16f;

  // Predict the outputs after the coming edge from the inputs applied now,
  // then advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    if (reset) begin
      m_pos  = 0;
      m_nsym = 0;
      m_link = 1'b0;
      exp_s  = 1'b0;
      exp_st = 1'b0;
      exp_bt = 1'b0;
      exp_la = 1'b0;
    end else begin
      if (m_pos == 0) begin
        if (m_nsym < int'(SYNC_SYMBOLS)) begin
          m_cur = 8'hBC;
          m_tk  = 1'b0;
        end else begin
          m_cur  = valid_in ? data_in : 8'h7C;
          m_tk   = valid_in;
          m_link = 1'b1;
        end
        m_nsym++;
      end
      exp_s  = m_cur[7 - m_pos];
      exp_st = (m_pos == 0);
      exp_bt = (m_pos == 0) && m_tk;
      exp_la = m_link;
      m_pos  = (m_pos + 1) % 8;
    end
    @(posedge clk_16f);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] rx;
    int         starts;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if ({serial_out, symbol_start, byte_taken, link_active} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=0000", c,
                 {serial_out, symbol_start, byte_taken, link_active});
      end
    end
    reset  = 1'b0;
    starts = 0;
    for (int s = 0; s < 4; s++) begin
      rx = 8'h00;
      for (int b = 0; b < 8; b++) begin
        tick();
        rx = {rx[6:0], serial_out};
        if (symbol_start === 1'b1) starts++;
        n_tests++;
        if ({serial_out, symbol_start, byte_taken, link_active} !== {exp_s, exp_st, exp_bt, exp_la}) begin
          n_fail++;
          $display("FAIL training_model sym=%0d bit=%0d got=%b exp=%b", s, b,
                   {serial_out, symbol_start, byte_taken, link_active}, {exp_s, exp_st, exp_bt, exp_la});
        end
      end
      n_tests++;
      if (rx !== 8'hBC) begin
        n_fail++;
        $display("FAIL training_symbol sym=%0d got=%h exp=bc", s, rx);
      end
    end
    n_tests++;
    if (starts != 4) begin
      n_fail++;
      $display("FAIL training_starts got=%0d exp=4", starts);
    end
  endtask

  task automatic test_idle();
    logic [7:0] rx;
    int         taken;
    valid_in = 1'b0;
    data_in  = 8'h5A;
    rx    = 8'h00;
    taken = 0;
    for (int b = 0; b < 8; b++) begin
      tick();
      rx = {rx[6:0], serial_out};
      if (byte_taken === 1'b1) taken++;
      if (b == 0) begin
        n_tests++;
        if ({link_active, symbol_start} !== 2'b11) begin
          n_fail++;
          $display("FAIL idle_link_rise got=%b exp=11", {link_active, symbol_start});
        end
      end
      n_tests++;
      if ({serial_out, symbol_start, byte_taken, link_active} !== {exp_s, exp_st, exp_bt, exp_la}) begin
        n_fail++;
        $display("FAIL idle_model bit=%0d got=%b exp=%b", b,
                 {serial_out, symbol_start, byte_taken, link_active}, {exp_s, exp_st, exp_bt, exp_la});
      end
    end
    n_tests++;
    if (rx !== 8'h7C || taken != 0) begin
      n_fail++;
      $display("FAIL idle_symbol got=%h taken=%0d exp=7c taken=0", rx, taken);
    end
  endtask

  task automatic test_data();
    logic [7:0] bytes [2];
    logic [7:0] rx;
    int         taken;
    bytes[0] = 8'hA5;
    bytes[1] = 8'h3C;
    for (int s = 0; s < 2; s++) begin
      valid_in = 1'b1;
      data_in  = bytes[s];
      rx    = 8'h00;
      taken = 0;
      for (int b = 0; b < 8; b++) begin
        tick();
        rx = {rx[6:0], serial_out};
        if (byte_taken === 1'b1) begin
          taken++;
          n_tests++;
          if (symbol_start !== 1'b1) begin
            n_fail++;
            $display("FAIL data_taken_align bit=%0d got=%b exp=1", b, symbol_start);
          end
        end
        n_tests++;
        if ({serial_out, symbol_start, byte_taken, link_active} !== {exp_s, exp_st, exp_bt, exp_la}) begin
          n_fail++;
          $display("FAIL data_model sym=%0d bit=%0d got=%b exp=%b", s, b,
                   {serial_out, symbol_start, byte_taken, link_active}, {exp_s, exp_st, exp_bt, exp_la});
        end
      end
      n_tests++;
      if (rx !== bytes[s] || taken != 1) begin
        n_fail++;
        $display("FAIL data_symbol sym=%0d got=%h taken=%0d exp=%h taken=1", s, rx, taken, bytes[s]);
      end
    end
  endtask

  task automatic test_midchange();
    logic [7:0] rx;
    valid_in = 1'b1;
    data_in  = 8'hF0;
    rx = 8'h00;
    for (int b = 0; b < 8; b++) begin
      tick();
      rx = {rx[6:0], serial_out};
      if (b == 2) data_in = 8'h0F;    // bit counter is now 3
      n_tests++;
      if ({serial_out, symbol_start, byte_taken, link_active} !== {exp_s, exp_st, exp_bt, exp_la}) begin
        n_fail++;
        $display("FAIL midchange_model bit=%0d got=%b exp=%b", b,
                 {serial_out, symbol_start, byte_taken, link_active}, {exp_s, exp_st, exp_bt, exp_la});
      end
    end
    n_tests++;
    if (rx !== 8'hF0) begin
      n_fail++;
      $display("FAIL midchange_first got=%h exp=f0", rx);
    end
    rx = 8'h00;
    for (int b = 0; b < 8; b++) begin
      tick();
      rx = {rx[6:0], serial_out};
    end
    n_tests++;
    if (rx !== 8'h0F) begin
      n_fail++;
      $display("FAIL midchange_second got=%h exp=0f", rx);
    end
  endtask

  task automatic test_gap();
    logic [7:0] exp_sym [3];
    logic       vld     [3];
    logic [7:0] rx;
    int         taken;
    exp_sym[0] = 8'h11; vld[0] = 1'b1;
    exp_sym[1] = 8'h7C; vld[1] = 1'b0;
    exp_sym[2] = 8'h22; vld[2] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      valid_in = vld[s];
      data_in  = vld[s] ? exp_sym[s] : 8'hEE;
      rx    = 8'h00;
      taken = 0;
      for (int b = 0; b < 8; b++) begin
        tick();
        rx = {rx[6:0], serial_out};
        if (byte_taken === 1'b1) taken++;
        n_tests++;
        if ({serial_out, symbol_start, byte_taken, link_active} !== {exp_s, exp_st, exp_bt, exp_la}) begin
          n_fail++;
          $display("FAIL gap_model sym=%0d bit=%0d got=%b exp=%b", s, b,
                   {serial_out, symbol_start, byte_taken, link_active}, {exp_s, exp_st, exp_bt, exp_la});
        end
      end
      n_tests++;
      if (rx !== exp_sym[s] || taken != int'(vld[s])) begin
        n_fail++;
        $display("FAIL gap_symbol sym=%0d got=%h taken=%0d exp=%h taken=%0d", s, rx, taken,
                 exp_sym[s], int'(vld[s]));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    int         link_seen;
    valid_in = 1'b1;
    data_in  = 8'hA5;
    for (int b = 0; b < 4; b++) tick();   // bit counter now 4
    reset = 1'b1;
    tick();
    n_tests++;
    if ({serial_out, symbol_start, byte_taken, link_active} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_clear got=%b exp=0000",
               {serial_out, symbol_start, byte_taken, link_active});
    end
    reset     = 1'b0;
    link_seen = 0;
    for (int s = 0; s < 5; s++) begin
      data_in = (s == 4) ? 8'h5A : 8'hA5;
      rx = 8'h00;
      for (int b = 0; b < 8; b++) begin
        tick();
        rx = {rx[6:0], serial_out};
        if (s < 4 && link_active !== 1'b0) link_seen++;
        n_tests++;
        if ({serial_out, symbol_start, byte_taken, link_active} !== {exp_s, exp_st, exp_bt, exp_la}) begin
          n_fail++;
          $display("FAIL reset_mid_model sym=%0d bit=%0d got=%b exp=%b", s, b,
                   {serial_out, symbol_start, byte_taken, link_active}, {exp_s, exp_st, exp_bt, exp_la});
        end
      end
      n_tests++;
      if (rx !== ((s == 4) ? 8'h5A : 8'hBC)) begin
        n_fail++;
        $display("FAIL reset_mid_symbol sym=%0d got=%h exp=%h", s, rx, (s == 4) ? 8'h5A : 8'hBC);
      end
    end
    n_tests++;
    if (link_seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid_link got=%0d cycles high exp=0", link_seen);
    end
  endtask

  // Random inputs changing every cycle, with occasional resets at any point.
  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 99) < 2);
      valid_in = $urandom_range(0, 1);
      data_in  = 8'($urandom);
      tick();
      n_tests++;
      if ({serial_out, symbol_start, byte_taken, link_active} !== {exp_s, exp_st, exp_bt, exp_la}) begin
        n_fail++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", c,
                 {serial_out, symbol_start, byte_taken, link_active}, {exp_s, exp_st, exp_bt, exp_la});
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    m_pos    = 0;
    m_nsym   = 0;
    m_cur    = 8'h00;
    m_tk     = 1'b0;
    m_link   = 1'b0;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    #2;
    test_reset();
    test_idle();
    test_data();
    test_midchange();
    test_gap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lane_par2serial_tx.md
Name: lane_par2serial_tx

Overview:
- Tx lane serialiser. Sits directly downstream of the 4-to-2 byte mux stage and consumes one of its 8-bit lane outputs plus the matching valid bit. Two instances are used, one per lane.
- After reset it sends a fixed training burst of COM symbols. It then streams each valid byte MSB-first on a 1-bit serial line, and substitutes the IDLE symbol whenever the input byte is not valid.
- Runs at 8x the byte rate of the lane it consumes.

Parameters:
- SYNC_SYMBOLS, 4: number of COM symbols sent after reset before data is accepted. Must be >= 1.
- COM_SYM, 8'hBC: training/comma symbol.
- IDLE_SYM, 8'h7C: symbol sent in ACTIVE when valid_in = 0.

Ports:
- clk_16f  input  1  bit clock; every register is rising-edge clocked on it.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  lane byte from the 4-to-2 mux stage.
- valid_in  input  1  data_in qualifier.
- serial_out  output  1  serial bit stream, MSB first.
- symbol_start  output  1  high in the cycle serial_out carries bit 7 of a symbol.
- byte_taken  output  1  one-cycle pulse: a valid data_in byte was consumed.
- link_active  output  1  high once data/idle symbols are being sent.

Behaviour:
- Reset (sampled on a clk_16f edge):
  - serial_out, symbol_start, byte_taken, link_active = 0.
  - Internal 3-bit bit_cnt = 0, 8-bit shift register = 0, sym_count = 0, state = SYNC.
  - Reset asserted mid-symbol truncates that symbol: outputs are 0 after that edge and no further bits of it are sent.
  - Reset held for multiple cycles keeps every output at 0.
- Load edge: any non-reset edge with bit_cnt == 0. The first edge after reset deasserts is a load edge.
  - Select symbol S (see states).
  - serial_out <= S[7]; shift register <= {S[6:0],1'b0}; bit_cnt <= 1; symbol_start <= 1.
- Shift edge: any non-reset edge with bit_cnt != 0.
  - serial_out <= shift register[7]; shift left by 1; bit_cnt <= bit_cnt+1, wrapping 7 -> 0; symbol_start <= 0.
- Symbol period is exactly 8 cycles, with no gaps. data_in/valid_in are sampled only on load edges; changes between load edges are ignored.
- State SYNC:
  - On each load edge S = COM_SYM and sym_count increments.
  - The load edge that sends COM number SYNC_SYMBOLS moves state to ACTIVE (sym_count == SYNC_SYMBOLS-1 before the increment).
  - valid_in is ignored; byte_taken stays 0.
- State ACTIVE:
  - On each load edge S = valid_in ? data_in : IDLE_SYM.
  - link_active <= 1 on the first ACTIVE load edge, so it rises together with symbol_start for the first non-COM symbol. It stays 1 until reset.
  - byte_taken <= valid_in on load edges and 0 on shift edges, giving a one-cycle pulse aligned with symbol_start.
- No exit from ACTIVE except reset.
- A data byte equal to COM_SYM or IDLE_SYM is sent unmodified; no escaping.
- sym_count width is sized for SYNC_SYMBOLS and never wraps in SYNC.
- Latency: serial_out carries bit 7 of the sampled byte starting one cycle after the load edge that sampled it; bit 0 follows 7 cycles later.

Test Plan:
1. Reset sequence, defaults: reset high 3 cycles, then low, valid_in = 0 → serial_out/symbol_start/byte_taken/link_active = 0 during reset. After release, serial_out over cycles 1-8 = 1,0,1,1,1,1,0,0 (0xBC), repeated 4 times, with symbol_start high on cycles 1, 9, 17, 25 and link_active = 0 throughout.
2. Idle fill: continue from scenario 1 with valid_in = 0 → cycle 33: link_active rises, symbol_start = 1. Cycles 33-40 serial_out = 0,1,1,1,1,1,0,0 (0x7C). byte_taken never pulses.
3. Data streaming: in ACTIVE, present valid bytes 0xA5 then 0x3C, each held for one 8-cycle window → serial_out = 10100101 then 00111100. byte_taken pulses once per byte, coincident with symbol_start.
4. Mid-symbol input change: valid_in = 1 with data_in = 0xF0 at a load edge, then change to 0x0F at bit_cnt = 3 → the full 0xF0 (11110000) is sent, and 0x0F is sent only if still present at the next load edge.
5. Valid gap: sequence valid 0x11, invalid, valid 0x22 → symbols 0x11, 0x7C, 0x22. byte_taken pulses on the 1st and 3rd symbol only.
6. Reset mid-operation: assert reset at bit_cnt = 4 of a data symbol in ACTIVE → all outputs 0 the next cycle and link_active drops. After release, the full 4-COM training is sent again before any data; no residual bits of the truncated symbol appear.
